// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: MEM-stage request/response bundle between the pipeline and the data memory
interface data_mem_ctrl_if;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_done;
    logic        access_err;
    modport master (output mem_read, mem_write, funct3, addr, wdata,
                    input  rdata, stall, mem_done, access_err);
    modport slave  (input  mem_read, mem_write, funct3, addr, wdata,
                    output rdata, stall, mem_done, access_err);
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle byte/half/word data memory with wait states, pipeline stall and access-error pulse
module data_mem_ctrl #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input logic            clk,
    input logic            rst_n,
    data_mem_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t                state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [2:0]            a_f3;
    logic [31:0]           a_wdata;
    logic                  a_wr;
    logic [31:0]           mem [DEPTH];
    logic                  idle, req, legal, accept, commit, op_wr;
    logic [2:0]            op_f3;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [31:0]           op_wdata, word, lane, load_val, store_val;
    logic [3:0]            be;
    logic                  unused_addr;

    assign unused_addr = ^bus.addr[31:ADDR_WIDTH];
    assign idle   = state == IDLE;
    assign req    = bus.mem_read | bus.mem_write;
    assign legal  = (bus.funct3 == 3'd0)
                  | (bus.funct3 == 3'd1 & ~bus.addr[0])
                  | (bus.funct3 == 3'd2 & bus.addr[1:0] == 2'b00)
                  | (~bus.mem_write & (bus.funct3 == 3'd4 | (bus.funct3 == 3'd5 & ~bus.addr[0])));
    assign accept = idle & req & legal;
    assign commit = rst_n & ((accept & WAIT_CYCLES == 0) | (state == WAIT & cnt == 4'd1));
    assign bus.stall = rst_n & (accept | state == WAIT);

    // With zero wait states the access commits straight from IDLE, so operands bypass the latches
    assign op_wr    = idle ? bus.mem_write : a_wr;
    assign op_f3    = idle ? bus.funct3 : a_f3;
    assign op_addr  = idle ? bus.addr[ADDR_WIDTH-1:0] : a_addr;
    assign op_wdata = idle ? bus.wdata : a_wdata;

    assign word      = mem[op_addr[ADDR_WIDTH-1:2]];
    assign lane      = word >> {op_addr[1:0], 3'b000};
    assign load_val  = op_f3[1] ? word
                     : op_f3[0] ? {{16{lane[15] & ~op_f3[2]}}, lane[15:0]}
                     : {{24{lane[7] & ~op_f3[2]}}, lane[7:0]};
    assign be        = op_f3[1] ? 4'hF : op_f3[0] ? (op_addr[1] ? 4'hC : 4'h3) : 4'b0001 << op_addr[1:0];
    assign store_val = op_f3[1] ? op_wdata : op_f3[0] ? {2{op_wdata[15:0]}} : {4{op_wdata[7:0]}};

    // Byte-lane store into the array on the edge that enters DONE
    always_ff @(posedge clk)
        if (commit & op_wr)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[op_addr[ADDR_WIDTH-1:2]][8*i +: 8] <= store_val[8*i +: 8];

    // Access sequencing, wait counter and registered responses
    always_ff @(posedge clk)
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            bus.rdata      <= 32'd0;
            bus.mem_done   <= 1'b0;
            bus.access_err <= 1'b0;
        end else begin
            bus.mem_done   <= commit;
            bus.access_err <= idle & req & ~legal;
            if (commit & ~op_wr) bus.rdata <= load_val;
            case (state)
                IDLE: if (accept) begin
                    a_addr  <= bus.addr[ADDR_WIDTH-1:0];
                    a_f3    <= bus.funct3;
                    a_wdata <= bus.wdata;
                    a_wr    <= bus.mem_write;
                    cnt     <= 4'(WAIT_CYCLES);
                    state   <= WAIT_CYCLES == 0 ? DONE : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: randomized and directed check of data_mem_ctrl against a word-array reference model
module tb_data_mem_ctrl;
    localparam int AW = 10;
    localparam int W  = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_ctrl_if bus();
    data_mem_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [31:0] model [256];
    logic [31:0] exp_rdata = 32'd0;
    logic exp_stall = 1'b0, exp_done = 1'b0, exp_err = 1'b0, pend_err = 1'b0, chk = 1'b0;
    int n_vec = 0, n_err = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (chk) begin
            cmp("stall", {31'd0, bus.stall}, {31'd0, exp_stall});
            cmp("mem_done", {31'd0, bus.mem_done}, {31'd0, exp_done});
            cmp("access_err", {31'd0, bus.access_err}, {31'd0, exp_err});
            cmp("rdata", bus.rdata, exp_rdata);
        end

    function automatic logic legal_m(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'd0: return 1'b1;
            3'd1: return !a[0];
            3'd2: return a[1:0] == 2'b00;
            3'd4: return !wr;
            3'd5: return !wr && !a[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_m(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w = model[a[AW-1:2]];
        logic [31:0] v = w >> (8 * int'(a[1:0]));
        case (f3)
            3'd0: return {{24{v[7]}}, v[7:0]};
            3'd1: return {{16{v[15]}}, v[15:0]};
            3'd4: return v & 32'hFF;
            3'd5: return v & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    function automatic void store_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int sh = (f3 == 3'd2) ? 0 : 8 * int'(a[1:0]);
        logic [31:0] m = ((f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFF_FFFF) << sh;
        model[a[AW-1:2]] = (model[a[AW-1:2]] & ~m) | ((wd << sh) & m);
    endfunction

    task automatic step(input logic rn, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic st, input logic dn);
        rst_n = rn; bus.mem_read = rd; bus.mem_write = wr; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
        exp_stall = st; exp_done = dn; exp_err = pend_err; pend_err = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        if (!(rd | wr)) step(1'b1, 1'b0, 1'b0, f3, a, wd, 1'b0, 1'b0);
        else if (!legal_m(wr, f3, a)) begin
            step(1'b1, rd, wr, f3, a, wd, 1'b0, 1'b0);
            pend_err = 1'b1;
        end else begin
            for (int k = 0; k <= W; k++) step(1'b1, rd, wr, f3, a, wd, 1'b1, 1'b0);
            if (wr) store_m(f3, a, wd);
            else exp_rdata = load_m(f3, a);
            step(1'b1, rd, wr, f3, a, wd, 1'b0, 1'b1);
        end
    endtask

    task automatic pin(input string name, input logic [31:0] lit);
        cmp(name, bus.rdata, lit);
        cmp({name, "_model"}, exp_rdata, lit);
    endtask

    initial begin
        logic r_rd, r_wr;
        logic [2:0] r_f3;
        logic [31:0] r_a;
        step(1'b0, 1'b1, 1'b0, 3'd2, 32'd0, 32'd0, 1'b0, 1'b0);
        chk = 1'b1;
        step(1'b0, 1'b1, 1'b0, 3'd2, 32'd0, 32'd0, 1'b0, 1'b0);
        pin("reset_rdata", 32'd0);
        for (int i = 0; i < 256; i++) access(1'b0, 1'b1, 3'd2, 32'(i * 4), 32'd0);
        access(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        access(1'b1, 1'b0, 3'd2, 32'h10, 32'd0);
        pin("lw_10", 32'hDEADBEEF);
        access(1'b0, 1'b1, 3'd0, 32'h13, 32'h80);
        access(1'b1, 1'b0, 3'd2, 32'h10, 32'd0);
        pin("sb_13_word", 32'h80ADBEEF);
        access(1'b1, 1'b0, 3'd0, 32'h13, 32'd0);
        pin("lb_13", 32'hFFFFFF80);
        access(1'b1, 1'b0, 3'd4, 32'h13, 32'd0);
        pin("lbu_13", 32'h00000080);
        access(1'b1, 1'b0, 3'd1, 32'h12, 32'd0);
        pin("lh_12", 32'hFFFF80AD);
        access(1'b1, 1'b0, 3'd5, 32'h12, 32'd0);
        pin("lhu_12", 32'h000080AD);
        access(1'b1, 1'b0, 3'd2, 32'h11, 32'd0);
        access(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        pin("err_rdata_kept", 32'h000080AD);
        access(1'b0, 1'b1, 3'd1, 32'h15, 32'hFFFF);
        access(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        access(1'b1, 1'b0, 3'd2, 32'h14, 32'd0);
        pin("sh_15_no_write", 32'd0);
        access(1'b1, 1'b0, 3'd3, 32'h10, 32'd0);
        access(1'b0, 1'b1, 3'd4, 32'h10, 32'd0);
        access(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 1'b1, 3'd2, 32'h20, 32'h12345678, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 3'd2, 32'h20, 32'h12345678, 1'b0, 1'b0);
        exp_rdata = 32'd0;
        access(1'b1, 1'b0, 3'd2, 32'h20, 32'd0);
        pin("reset_drops_store", 32'd0);
        access(1'b1, 1'b1, 3'd2, 32'h8, 32'hA5A5A5A5);
        access(1'b1, 1'b0, 3'd2, 32'h408, 32'd0);
        pin("alias_408", 32'hA5A5A5A5);
        access(1'b1, 1'b0, 3'd2, 32'h10, 32'd0);
        access(1'b1, 1'b0, 3'd0, 32'h13, 32'd0);
        pin("back_to_back", 32'hFFFFFF80);
        for (int n = 0; n < 400; n++) begin
            r_rd = 1'($urandom_range(0, 1));
            r_wr = 1'($urandom_range(0, 1));
            r_f3 = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            if ($urandom_range(0, 3) != 0) r_a[1:0] = 2'b00;
            access(r_rd, r_wr, r_f3, r_a, $urandom);
        end
        access(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
